// File: rtl/frame_pkg.sv
// frame_pkg: shared frame FSM states and link defaults for the serial transmitter and receiver
package frame_pkg;
  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, STUFF, GAP} state_t;
  localparam int DEF_NBITS = 8;
  localparam int DEF_PREAMBLE_LEN = 3;
  localparam int DEF_GAP_LEN = 1;
endpackage

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: MSB-first frame transmitter with ones preamble, zero stuffing and trailing gap
module serial_frame_tx
  import frame_pkg::*;
#(
  parameter int NBITS = DEF_NBITS,
  parameter int PREAMBLE_LEN = DEF_PREAMBLE_LEN,
  parameter int GAP_LEN = DEF_GAP_LEN
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             start,
  input  logic [NBITS-1:0] data_in,
  output logic             out_bit,
  output logic             bit_valid,
  output logic             stuff_bit,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(NBITS + 1);
  localparam int RW = $clog2(PREAMBLE_LEN);
  localparam int PMAX = PREAMBLE_LEN > GAP_LEN ? PREAMBLE_LEN : GAP_LEN;
  localparam int PW = $clog2(PMAX + 1);
  state_t state, ns;
  logic [NBITS-1:0] sr, sr_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [PW-1:0] pcnt, pcnt_d;
  logic [RW-1:0] run, run_d;
  always_comb begin
    ns = state;
    sr_d = sr;
    cnt_d = cnt;
    pcnt_d = pcnt;
    run_d = run;
    case (state)
      IDLE: if (start) begin
        ns = PREAMBLE;
        sr_d = data_in;
        cnt_d = '0;
        pcnt_d = '0;
      end
      PREAMBLE: begin
        pcnt_d = pcnt + 1'b1;
        if (pcnt_d == PW'(PREAMBLE_LEN)) begin
          ns = DATA;
          pcnt_d = '0;
          run_d = '0;
        end
      end
      DATA: begin
        sr_d = sr << 1;
        cnt_d = cnt + 1'b1;
        run_d = sr[NBITS-1] ? (&run ? run : run + 1'b1) : '0;
        ns = run_d == RW'(PREAMBLE_LEN - 1) ? STUFF : cnt_d == CW'(NBITS) ? GAP : DATA;
      end
      STUFF: begin
        run_d = '0;
        ns = cnt == CW'(NBITS) ? GAP : DATA;
      end
      GAP: begin
        pcnt_d = pcnt + 1'b1;
        if (pcnt_d == PW'(GAP_LEN)) begin
          ns = IDLE;
          pcnt_d = '0;
        end
      end
      default: ns = IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with the cycle they describe
  always_ff @(posedge clk_2) begin
    if (!reset) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      pcnt <= '0;
      run <= '0;
      out_bit <= 1'b0;
      bit_valid <= 1'b0;
      stuff_bit <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= ns;
      sr <= sr_d;
      cnt <= cnt_d;
      pcnt <= pcnt_d;
      run <= run_d;
      out_bit <= ns == PREAMBLE || (ns == DATA && sr_d[NBITS-1]);
      bit_valid <= ns != IDLE;
      stuff_bit <= ns == STUFF;
      busy <= ns != IDLE;
      done <= state == GAP && ns == IDLE;
    end
  end
endmodule
